// File: rtl/credit_manager_pkg.sv
// -----------------------------------------------------------------------------
// credit_manager_pkg
// Shared definitions for the slot-machine credit manager: FSM state
// encodings, default parameter values, and a helper that picks the count-up
// step for the payout animation.
// -----------------------------------------------------------------------------
package credit_manager_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SPIN = 2'd1,
        ST_PAY  = 2'd2
    } state_t;

    localparam int unsigned DEF_START_CREDITS = 32'd100;
    localparam int unsigned DEF_BET           = 32'd1;
    localparam int unsigned DEF_BIG_STEP      = 32'd10;
    localparam int unsigned DEF_BIG_MIN       = 32'd100;

    // Large wins count up in big increments so the animation stays short;
    // the tail end counts one credit at a time.
    function automatic logic [15:0] pay_step(
        input logic [15:0] remaining,
        input logic [15:0] big_step,
        input logic [15:0] big_min
    );
        logic [15:0] step;
        if (remaining >= big_min) begin
            step = big_step;
        end else begin
            step = 16'd1;
        end
        return step;
    endfunction

endpackage

// File: rtl/credit_manager_sat_add16.sv
// -----------------------------------------------------------------------------
// sat_add16
// 16-bit unsigned saturating adder. The sum is formed 17 bits wide so no
// wrap-around can occur; any sum reaching 16'hFFFF clamps to 16'hFFFF.
// Ports:
//   i_a, i_b  in  16  operands
//   o_sum     out 16  clamped sum
//   o_sat     out 1   high when the result was clamped
// -----------------------------------------------------------------------------
module sat_add16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_sum,
    output logic        o_sat
);

    logic [16:0] w_sum17;

    assign w_sum17 = {1'b0, i_a} + {1'b0, i_b};

    // Clamp: reaching the all-ones value counts as saturation.
    always_comb begin
        if (w_sum17 >= 17'h0FFFF) begin
            o_sat = 1'b1;
            o_sum = 16'hFFFF;
        end else begin
            o_sat = 1'b0;
            o_sum = w_sum17[15:0];
        end
    end

endmodule

// File: rtl/credit_manager.sv
// -----------------------------------------------------------------------------
// credit_manager
// Credit bookkeeping for a slot machine. A spin costs BET credits; when the
// reels stop the payout is counted back into the balance one tick at a time.
// Ports:
//   clk          in  1   clock, rising edge
//   rst_n        in  1   asynchronous active-low reset
//   tick         in  1   count-up pacing strobe
//   spin_btn     in  1   spin request
//   reels_done   in  1   reels stopped, payout valid
//   payout       in  16  win amount
//   spin_start   out 1   registered pulse starting the reels
//   credits      out 16  credit balance (registered)
//   win_display  out 16  current/last win (registered)
//   busy         out 1   state is not IDLE
//   no_credit    out 1   credits below BET
// -----------------------------------------------------------------------------
module credit_manager
    import credit_manager_pkg::*;
#(
    parameter int unsigned START_CREDITS = DEF_START_CREDITS,
    parameter int unsigned BET           = DEF_BET,
    parameter int unsigned BIG_STEP      = DEF_BIG_STEP,
    parameter int unsigned BIG_MIN       = DEF_BIG_MIN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        spin_btn,
    input  logic        reels_done,
    input  logic [15:0] payout,
    output logic        spin_start,
    output logic [15:0] credits,
    output logic [15:0] win_display,
    output logic        busy,
    output logic        no_credit
);

    localparam logic [15:0] START16    = 16'(START_CREDITS);
    localparam logic [15:0] BET16      = 16'(BET);
    localparam logic [15:0] BIG_STEP16 = 16'(BIG_STEP);
    localparam logic [15:0] BIG_MIN16  = 16'(BIG_MIN);

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_credits;
    logic [15:0] r_win;
    logic [15:0] r_remaining;
    logic        r_spin_start;

    logic        w_spin_ok;
    logic [15:0] w_step;
    logic [15:0] w_credit_sum;
    logic        w_sat;
    logic        w_pay_last;

    assign w_spin_ok = (r_state == ST_IDLE) && spin_btn && (r_credits >= BET16);
    assign w_step    = pay_step(r_remaining, BIG_STEP16, BIG_MIN16);
    // Last count-up tick: either the balance clamps or the remainder is used up
    // (<= also covers a remainder smaller than the step).
    assign w_pay_last = w_sat || (r_remaining <= w_step);

    sat_add16 u_sat_add (
        .i_a   (r_credits),
        .i_b   (w_step),
        .o_sum (w_credit_sum),
        .o_sat (w_sat)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_spin_ok) begin
                    w_next_state = ST_SPIN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SPIN: begin
                if (reels_done) begin
                    w_next_state = (payout != 16'd0) ? ST_PAY : ST_IDLE;
                end else begin
                    w_next_state = ST_SPIN;
                end
            end
            ST_PAY: begin
                if (tick && w_pay_last) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_PAY;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Status outputs decoded from registered state.
    always_comb begin
        busy      = (r_state != ST_IDLE);
        no_credit = (r_credits < BET16);
    end

    // Credit, win and remaining-payout datapath plus the spin_start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits    <= START16;
            r_win        <= 16'd0;
            r_remaining  <= 16'd0;
            r_spin_start <= 1'b0;
        end else begin
            r_spin_start <= w_spin_ok;
            case (r_state)
                ST_IDLE: begin
                    if (w_spin_ok) begin
                        r_credits <= r_credits - BET16;
                        r_win     <= 16'd0;
                    end
                end
                ST_SPIN: begin
                    if (reels_done) begin
                        r_win       <= payout;
                        r_remaining <= payout;
                    end
                end
                ST_PAY: begin
                    if (tick) begin
                        r_credits   <= w_credit_sum;
                        // Saturation discards whatever was still owed.
                        r_remaining <= w_pay_last ? 16'd0 : (r_remaining - w_step);
                    end
                end
                default: begin
                    r_remaining <= 16'd0;
                end
            endcase
        end
    end

    assign spin_start  = r_spin_start;
    assign credits     = r_credits;
    assign win_display = r_win;

endmodule

// File: doc/credit_manager.md
CREDIT_MANAGER -- requirements
Module: credit_manager

Interface
REQ-001 Parameter START_CREDITS, default 100, is the credit balance loaded at reset.
REQ-002 Parameter BET, default 1, is the credits deducted per spin.
REQ-003 Parameter BIG_STEP, default 10, is the count-up increment while the remaining win is at least BIG_MIN.
REQ-004 Parameter BIG_MIN, default 100, is the remaining-win threshold for BIG_STEP.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 tick  in  1  single-cycle count-up pacing strobe (frame rate).
REQ-008 spin_btn  in  1  single-cycle spin request (debounced upstream).
REQ-009 reels_done  in  1  single-cycle pulse; all reels stopped and payout valid.
REQ-010 payout  in  16  win amount in credits from the payout table, valid when reels_done=1.
REQ-011 spin_start  out  1  registered single-cycle pulse that starts the reels.
REQ-012 credits  out  16  current credit balance.
REQ-013 win_display  out  16  amount of the current/last win.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 no_credit  out  1  high when credits < BET.

Function
REQ-016 The FSM SHALL have three states: IDLE, SPIN and PAY.
REQ-017 IDLE, spin_btn=1, credits>=BET: at that edge, credits -= BET, win_display := 0, state := SPIN, and spin_start = 1 for exactly the following cycle.
REQ-018 IDLE, spin_btn=1, credits<BET: request ignored; no state change; no spin_start.
REQ-019 spin_btn in SPIN or PAY SHALL be ignored and not queued.
REQ-020 SPIN, reels_done=1: at that edge, payout is captured into win_display and the internal 16-bit remaining register; state := PAY if payout!=0, else IDLE.
REQ-021 reels_done outside SPIN, and tick outside PAY, SHALL be ignored.
REQ-022 PAY, tick=1: step = BIG_STEP if remaining>=BIG_MIN, else 1; credits += step; remaining -= step.
REQ-023 When remaining reaches 0, state SHALL become IDLE at that same edge.
REQ-024 Saturation: if credits+step >= 65535, credits := 65535, remaining := 0, state := IDLE; the excess is discarded and win_display is unchanged.
REQ-025 The credits sum SHALL be computed 17 bits wide; no wrap-around is permitted.
REQ-026 win_display SHALL hold its value in IDLE until the next accepted spin.
REQ-027 busy and no_credit SHALL be combinational from registered state; spin_start, credits and win_display SHALL be registers.

Reset
REQ-028 rst_n=0 asynchronously forces: state IDLE, credits START_CREDITS, win_display 0, remaining 0, spin_start 0.
REQ-029 Reset during SPIN or PAY SHALL abandon the spin and any uncredited remainder.
REQ-030 The first accepted spin_btn SHALL be the one sampled on the first edge after rst_n deasserts.

Structure
REQ-031 FSM state encodings and default values for START_CREDITS, BET, BIG_STEP and BIG_MIN SHALL live in the shared defs.vh alongside the symbol codes.
REQ-032 A single sub-module, sat_add16 (16-bit saturating adder with a saturated flag), is natural for REQ-024/REQ-025.

Verification
REQ-033 Reset release -> credits=100, win_display=0, busy=0, spin_start=0, no_credit=0.
REQ-034 spin_btn, then reels_done with payout=0 -> credits=99, exactly one spin_start pulse, IDLE the cycle after reels_done, win_display=0.
REQ-035 Spin, then payout=25 -> 25 ticks of +1, credits 99->124, busy falls on the 25th tick edge, win_display=25.
REQ-036 Spin, then payout=5000 -> 491 ticks of +10 then 90 ticks of +1 (581 total), final credits=5099.
REQ-037 100 spins with payout=0 -> credits=0, no_credit=1; further spin_btn gives no spin_start and busy stays 0.
REQ-038 START_CREDITS=65530, spin, payout=10 -> credits 65529, saturates to 65535 on the 6th tick, then IDLE with win_display=10; rst_n pulsed mid-PAY -> credits=START_CREDITS, IDLE immediately.
